regfile_pipe: RTL and testbench
===============================

REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W, 16, register width in bits
  ADDR_W, 3, address width; NREGS = 2**ADDR_W registers
  PC_IDX, 7, index of the program-counter register
  RESET_PC, 0, PC value loaded at reset
  BYPASS, 1, 1 = write-to-read forwarding enabled
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  input  1  single clock, all state updates on rising edge
  reset  input  1  asynchronous, active-low reset
  rd_addr1  input  ADDR_W  read port 1 address
  rd_addr2  input  ADDR_W  read port 2 address
  rd_data1  output  DATA_W  read port 1 data
  rd_data2  output  DATA_W  read port 2 data
  rd_busy1  output  1  register at rd_addr1 has a pending writer
  rd_busy2  output  1  register at rd_addr2 has a pending writer
  wr_en  input  1  general write enable
  wr_addr  input  ADDR_W  general write address
  wr_data  input  DATA_W  general write data
  pc_wr  input  1  dedicated PC load
  pc_data  input  DATA_W  dedicated PC load value
  pc_inc  input  1  PC increment request
  pc_out  output  DATA_W  current PC register value
  claim_en  input  1  mark a register as pending write (issue)
  claim_addr  input  ADDR_W  register being claimed
  claim_err  output  1  sticky: claim made on an already-busy register

Function
REQ-003 Reads SHALL be combinational from the current register contents, zero cycles latency.
REQ-004 With BYPASS=1, a read whose address equals wr_addr while wr_en=1 SHALL return wr_data in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-005 wr_en=1 SHALL write wr_data into wr_addr on the next rising edge, for every address including PC_IDX.
REQ-006 PC update priority per cycle: general write to PC_IDX > pc_wr (load pc_data) > pc_inc (PC+1, modulo 2**DATA_W) > hold.
REQ-007 PC increment SHALL wrap from all-ones to zero without error indication.
REQ-008 Reads of PC_IDX SHALL observe the same bypass rule as other registers, with pc_wr also forwarded when BYPASS=1 and no general write targets PC_IDX.
REQ-009 pc_out SHALL always equal the stored PC register (no bypass).
REQ-010 Scoreboard: one busy bit per register; claim_en SHALL set busy[claim_addr] on the next edge.
REQ-011 wr_en SHALL clear busy[wr_addr] on the next edge.
REQ-012 Simultaneous claim and write to the same address SHALL leave busy set (new claim wins); data is still written.
REQ-013 rd_busyN SHALL reflect busy[rd_addrN] combinationally; with BYPASS=1 it SHALL read 0 when the same cycle's write clears that register.
REQ-014 claim_en on a register whose busy is 1 and not cleared the same cycle SHALL set claim_err, held until reset.
REQ-015 pc_wr and pc_inc SHALL not affect busy bits.

Reset
REQ-016 reset low SHALL immediately (asynchronously) set all non-PC registers to 0, PC to RESET_PC, all busy bits to 0, claim_err to 0.
REQ-017 While reset is low, writes, claims and PC updates SHALL be ignored; operation resumes on the first rising edge after deassertion.

Structure
REQ-018 A shared package SHALL hold the default width/address constants and the PC index so the decoder and datapath reuse them.
REQ-019 One sub-module, regfile_scoreboard (busy bits, claim_err), SHALL be instantiated; storage and bypass stay in regfile_pipe.

Verification
REQ-020 Reset release, read all 8 addresses -> R0..R6 = 0x0000, PC = RESET_PC, rd_busy* = 0, claim_err = 0.
REQ-021 wr_en=1, wr_addr=3, wr_data=0xBEEF with rd_addr1=3 -> rd_data1=0xBEEF same cycle (BYPASS=1), stored value 0xBEEF next cycle; BYPASS=0 shows old 0x0000 first.
REQ-022 PC=0xFFFF, pc_inc=1 -> PC=0x0000; same cycle wr_en to addr 7 with 0x0040 plus pc_wr=0x0100 plus pc_inc -> PC=0x0040.
REQ-023 claim addr 5, next cycle rd_addr2=5 -> rd_busy2=1; write addr 5 -> busy cleared next edge, rd_busy2=0 during write cycle.
REQ-024 claim addr 2 twice without intervening write -> claim_err=1 and stays 1; claim+write addr 2 same cycle -> busy remains 1, no error.
REQ-025 Assert reset mid-sequence (after writes and claims) -> all outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/regfile_pipe_pkg.sv
// rtl/regfile_pipe_pkg.sv - shared default widths and program-counter index for the register file
package regfile_pipe_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_PC_IDX = 7;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-writer bits and sticky double-claim error
module regfile_scoreboard
  import regfile_pipe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              claim_err
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] clr_now;
  logic             err_set;

  // A claim in the same cycle as a write to that register wins, so it is not a clear.
  always_comb begin
    clr_now   = '0;
    busy_next = busy;
    for (int i = 0; i < NREGS; i++) begin
      clr_now[i] = wr_en && (wr_addr == ADDR_W'(i)) && !(claim_en && (claim_addr == ADDR_W'(i)));
      if (claim_en && (claim_addr == ADDR_W'(i)))
        busy_next[i] = 1'b1;
      else if (wr_en && (wr_addr == ADDR_W'(i)))
        busy_next[i] = 1'b0;
    end
  end

  assign err_set = claim_en && busy[claim_addr] && !(wr_en && (wr_addr == claim_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      claim_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (err_set)
        claim_err <= 1'b1;
    end
  end

  assign rd_busy1 = busy[rd_addr1] && !(BYPASS && clr_now[rd_addr1]);
  assign rd_busy2 = busy[rd_addr2] && !(BYPASS && clr_now[rd_addr2]);
endmodule

// File: rtl/regfile_pipe.sv
// rtl/regfile_pipe.sv - two-read one-write register file with dedicated PC register and issue scoreboard
module regfile_pipe
  import regfile_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter int RESET_PC = 0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_wr,
  input  logic [DATA_W-1:0] pc_data,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc_out,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_err
);
  localparam int                NREGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] RST_PC = DATA_W'(RESET_PC);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] pc_next;
  logic              wr_pc;

  assign wr_pc = wr_en && (wr_addr == PC_A);

  always_comb begin
    pc_next = regs[PC_IDX];
    if (wr_pc)
      pc_next = wr_data;
    else if (pc_wr)
      pc_next = pc_data;
    else if (pc_inc)
      pc_next = regs[PC_IDX] + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == PC_IDX) ? RST_PC : '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == PC_IDX)
          regs[i] <= pc_next;
        else if (wr_en && (wr_addr == ADDR_W'(i)))
          regs[i] <= wr_data;
      end
    end
  end

  // Only the general write and the PC load are forwarded; an increment shows next cycle.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (BYPASS && wr_en && (wr_addr == rd_addr1))
      rd_data1 = wr_data;
    else if (BYPASS && pc_wr && (rd_addr1 == PC_A))
      rd_data1 = pc_data;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (BYPASS && wr_en && (wr_addr == rd_addr2))
      rd_data2 = wr_data;
    else if (BYPASS && pc_wr && (rd_addr2 == PC_A))
      rd_data2 = pc_data;
  end

  assign pc_out = regs[PC_IDX];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_busy1   (rd_busy1),
    .rd_busy2   (rd_busy2),
    .claim_err  (claim_err)
  );
endmodule

// File: tb/tb_regfile_pipe.sv
// tb/tb_regfile_pipe.sv - scoreboard bench for regfile_pipe with bypassing and non-bypassing instances
module tb_regfile_pipe;
  localparam logic [15:0] RPC = 16'h0010;

  typedef enum int {S_RD1, S_RD2, S_BUSY1, S_BUSY2, S_PC, S_ERR, S_RD1NB} sig_t;
  typedef struct {
    string       name;
    sig_t        sig;
    logic [15:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, claim_addr = '0;
  logic [15:0] wr_data = '0, pc_data = '0;
  logic        wr_en = 1'b0, pc_wr = 1'b0, pc_inc = 1'b0, claim_en = 1'b0;

  logic [15:0] rd_data1, rd_data2, pc_out;
  logic        rd_busy1, rd_busy2, claim_err;
  logic [15:0] nb_rd_data1, nb_rd_data2, nb_pc_out;
  logic        nb_rd_busy1, nb_rd_busy2, nb_claim_err;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  regfile_pipe #(.RESET_PC(16'h0010), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr(pc_wr), .pc_data(pc_data), .pc_inc(pc_inc), .pc_out(pc_out),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_err(claim_err)
  );

  regfile_pipe #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
    .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr(pc_wr), .pc_data(pc_data), .pc_inc(pc_inc), .pc_out(nb_pc_out),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_err(nb_claim_err)
  );

  function automatic logic [15:0] actual(input sig_t s);
    case (s)
      S_RD1:   return rd_data1;
      S_RD2:   return rd_data2;
      S_BUSY1: return {15'd0, rd_busy1};
      S_BUSY2: return {15'd0, rd_busy2};
      S_PC:    return pc_out;
      S_ERR:   return {15'd0, claim_err};
      default: return nb_rd_data1;
    endcase
  endfunction

  // Monitor: everything expected for the current cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [15:0] a;
      e = exp_q.pop_front();
      a = actual(e.sig);
      total++;
      if (a !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input sig_t s, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    pc_wr    = 1'b0;
    pc_inc   = 1'b0;
    claim_en = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      cyc();
      rd_addr1 = 3'(a);
      rd_addr2 = 3'(a);
      expect_v($sformatf("reset_rd1_r%0d", a), S_RD1, (a == 7) ? RPC : 16'h0000);
      expect_v($sformatf("reset_rd2_r%0d", a), S_RD2, (a == 7) ? RPC : 16'h0000);
      expect_v("reset_busy1", S_BUSY1, 16'h0);
      expect_v("reset_busy2", S_BUSY2, 16'h0);
    end
    expect_v("reset_err", S_ERR, 16'h0);
    expect_v("reset_pc", S_PC, RPC);

    // Write with forwarding vs. without
    cyc(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr1 = 3'd3;
    expect_v("byp_rd1", S_RD1, 16'hBEEF);
    expect_v("nobyp_rd1_old", S_RD1NB, 16'h0000);
    cyc(); idle();
    expect_v("byp_rd1_stored", S_RD1, 16'hBEEF);
    expect_v("nobyp_rd1_stored", S_RD1NB, 16'hBEEF);

    // PC load, wrap, and write/load/inc priority
    cyc(); pc_wr = 1'b1; pc_data = 16'hFFFF; rd_addr1 = 3'd7;
    expect_v("pcwr_fwd", S_RD1, 16'hFFFF);
    expect_v("pcwr_pc_hold", S_PC, RPC);
    cyc(); pc_wr = 1'b0; pc_inc = 1'b1;
    expect_v("pc_loaded", S_PC, 16'hFFFF);
    expect_v("pcinc_no_fwd", S_RD1, 16'hFFFF);
    cyc(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0040; pc_wr = 1'b1; pc_data = 16'h0100;
    expect_v("pc_wrapped", S_PC, 16'h0000);
    expect_v("pc_prio_fwd", S_RD1, 16'h0040);
    cyc(); idle();
    expect_v("pc_prio", S_PC, 16'h0040);
    expect_v("pc_prio_rd", S_RD1, 16'h0040);

    // Claim then write on r5
    cyc(); claim_en = 1'b1; claim_addr = 3'd5; rd_addr2 = 3'd5;
    expect_v("claim5_not_yet", S_BUSY2, 16'h0);
    cyc(); idle();
    expect_v("claim5_busy", S_BUSY2, 16'h1);
    cyc(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    expect_v("wr5_busy_byp", S_BUSY2, 16'h0);
    expect_v("wr5_rd2", S_RD2, 16'h1234);
    cyc(); idle();
    expect_v("wr5_cleared", S_BUSY2, 16'h0);
    expect_v("wr5_no_err", S_ERR, 16'h0);

    // Claim+write same register keeps busy, no error; second claim errors
    cyc(); claim_en = 1'b1; claim_addr = 3'd2; rd_addr1 = 3'd2;
    expect_v("claim2_not_yet", S_BUSY1, 16'h0);
    cyc(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
    expect_v("cw2_busy", S_BUSY1, 16'h1);
    expect_v("cw2_rd1", S_RD1, 16'h5555);
    cyc(); idle();
    expect_v("cw2_still_busy", S_BUSY1, 16'h1);
    expect_v("cw2_no_err", S_ERR, 16'h0);
    expect_v("cw2_stored", S_RD1, 16'h5555);
    cyc(); claim_en = 1'b1;
    expect_v("dbl_claim_err_not_yet", S_ERR, 16'h0);
    cyc(); idle();
    expect_v("dbl_claim_err", S_ERR, 16'h1);
    expect_v("dbl_claim_busy", S_BUSY1, 16'h1);
    cyc();
    expect_v("err_sticky", S_ERR, 16'h1);

    // Asynchronous reset mid-sequence, then ignored activity while held
    cyc(); claim_en = 1'b1; claim_addr = 3'd6;
    cyc(); idle(); rd_addr1 = 3'd3; rd_addr2 = 3'd6;
    expect_v("pre_rst_busy6", S_BUSY2, 16'h1);
    cyc();
    reset_n = 1'b0;
    expect_v("arst_rd1", S_RD1, 16'h0000);
    expect_v("arst_nb_rd1", S_RD1NB, 16'h0000);
    expect_v("arst_busy2", S_BUSY2, 16'h0);
    expect_v("arst_err", S_ERR, 16'h0);
    expect_v("arst_pc", S_PC, RPC);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hAAAA; claim_en = 1'b1; claim_addr = 3'd6;
    pc_inc = 1'b1; rd_addr1 = 3'd1;
    cyc(); idle(); reset_n = 1'b1; rd_addr1 = 3'd4;
    expect_v("rst_ignored_wr", S_RD1, 16'h0000);
    expect_v("rst_ignored_claim", S_BUSY2, 16'h0);
    expect_v("rst_ignored_pc", S_PC, RPC);
    cyc(); pc_inc = 1'b1;
    cyc(); idle();
    expect_v("resume_pc_inc", S_PC, RPC + 16'h1);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
